// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment controller: register
// offsets, CTRL field layout, reset value and the hex -> segment table.
package seg7_pkg;

    // CTRL register layout: [0] EN, [3:1] reserved, [7:4] BRIGHT
    localparam int         CTRL_EN_BIT     = 0;
    localparam int         CTRL_BRIGHT_LSB = 4;
    localparam int         BRIGHT_W        = 4;
    localparam logic [7:0] CTRL_RESET      = 8'hF0;

    // Which register a bus address selects
    typedef enum logic [1:0] {
        REG_DIGIT,
        REG_DPMASK,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    // Active-high segment patterns, bit order g..a, indexed by hex value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    // DPMASK sits right after the P digit-pair registers, CTRL after that
    function automatic int ofs_dpmask(input int pairs);
        return pairs;
    endfunction

    function automatic int ofs_ctrl(input int pairs);
        return pairs + 1;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_mux_controller.sv
// Bus-mapped, N-digit multiplexed 7-segment display controller with
// decimal-point mask, 16-level brightness PWM, frame-synchronous double
// buffering of digit/DP data, and registered bus readback.
module seg7_mux_controller
    import seg7_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hD0,
    parameter int         NUM_DIGITS = 4,
    parameter int         DWELL_LOG2 = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            BUS_ADDR,
    inout  wire  [7:0]            BUS_DATA,
    input  logic                  BUS_WE,
    output logic [7:0]            HEX_OUT,
    output logic [NUM_DIGITS-1:0] SEG_SELECT
);

    localparam int                PAIRS    = NUM_DIGITS / 2;
    localparam int                IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Staging (bus-visible) and active (displayed) copies of digit/DP data
    logic [4*NUM_DIGITS-1:0] stage_dig;
    logic [4*NUM_DIGITS-1:0] active_dig;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic [NUM_DIGITS-1:0]   active_dp;

    // CTRL is not double-buffered
    logic                    ctrl_en;
    logic [BRIGHT_W-1:0]     ctrl_bright;

    // Readback path
    logic [7:0]              rd_data;
    logic [7:0]              rd_next;
    logic                    drive_en;

    // Scan state
    logic [DWELL_LOG2-1:0]   dwell;
    logic [IDX_W-1:0]        idx;
    logic                    dwell_wrap;
    logic                    frame_end;

    // Address decode
    logic [7:0]              offset;
    reg_sel_e                reg_sel;
    int                      pair;

    // Display path
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;
    logic [BRIGHT_W-1:0]     level;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    assign offset     = BUS_ADDR - BASE_ADDR;
    assign dwell_wrap = &dwell;
    assign frame_end  = dwell_wrap && (idx == LAST_IDX);
    assign level      = dwell[DWELL_LOG2-1 -: BRIGHT_W];

    assign BUS_DATA   = drive_en ? rd_data : 8'hzz;

    // Classify the bus address into one of the register kinds
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        reg_sel = REG_NONE;
        pair    = 0;
        if (int'(offset) < PAIRS) begin
            reg_sel = REG_DIGIT;
            pair    = int'(offset);
        end else if (int'(offset) == ofs_dpmask(PAIRS)) begin
            reg_sel = REG_DPMASK;
        end else if (int'(offset) == ofs_ctrl(PAIRS)) begin
            reg_sel = REG_CTRL;
        end
    end

    // Readback mux: staging values and CTRL with reserved bits as zero
    always_comb begin
        rd_next = '0;
        case (reg_sel)
            REG_DIGIT:  rd_next = stage_dig[8*pair +: 8];
            REG_DPMASK: rd_next = 8'(stage_dp);
            REG_CTRL:   rd_next = {ctrl_bright, 3'b000, ctrl_en};
            default:    rd_next = '0;
        endcase
    end

    // Bus writes into staging/CTRL and registered readback
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: these are a handful of flops, not a RAM, so they are reset
            // directly; a mid-frame reset must discard pending staging data.
            stage_dig   <= '0;
            stage_dp    <= '0;
            ctrl_en     <= CTRL_RESET[CTRL_EN_BIT];
            ctrl_bright <= CTRL_RESET[CTRL_BRIGHT_LSB +: BRIGHT_W];
            rd_data     <= '0;
            drive_en    <= 1'b0;
        end else begin
            drive_en <= 1'b0;
            if (BUS_WE) begin
                case (reg_sel)
                    REG_DIGIT:  stage_dig[8*pair +: 8] <= BUS_DATA;
                    REG_DPMASK: stage_dp <= BUS_DATA[NUM_DIGITS-1:0];
                    REG_CTRL: begin
                        ctrl_en     <= BUS_DATA[CTRL_EN_BIT];
                        ctrl_bright <= BUS_DATA[CTRL_BRIGHT_LSB +: BRIGHT_W];
                    end
                    default: ;
                endcase
            end else if (reg_sel != REG_NONE) begin
                rd_data  <= rd_next;
                drive_en <= 1'b1;
            end
        end
    end

    // Frame-synchronous commit of staging into the displayed copy
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            active_dig <= '0;
            active_dp  <= '0;
        end else if (frame_end) begin
            // NOTE: non-blocking assignment means a write landing on the commit
            // edge is not seen here; the old staging value is committed and the
            // new one waits for the next frame.
            active_dig <= stage_dig;
            active_dp  <= stage_dp;
        end
    end

    // Free-running dwell counter; digit index advances on each dwell wrap
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dwell <= '0;
            idx   <= '0;
        end else begin
            dwell <= dwell + 1'b1;
            if (dwell_wrap) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Select the current digit's nibble, its anode bit and the PWM gate
    always_comb begin
        cur_nibble      = active_dig[4*int'(idx) +: 4];
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
        lit             = ctrl_en && (level <= ctrl_bright);
    end

    seg7_decoder u_decoder (
        .nibble   (cur_nibble),
        .segments (cur_seg)
    );

    // Registered active-low anode and cathode drive
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            HEX_OUT    <= 8'hFF;
            SEG_SELECT <= '1;
        end else if (lit) begin
            HEX_OUT    <= {~active_dp[idx], ~cur_seg};
            SEG_SELECT <= ~sel_onehot;
        end else begin
            HEX_OUT    <= 8'hFF;
            SEG_SELECT <= '1;
        end
    end

endmodule

// File: tb/tb_seg7_mux_controller.sv
// Self-checking bench for seg7_mux_controller (4 digits, 16-cycle dwell).
// A cycle model pushes the expected display outputs into a scoreboard queue
// on every clock; a checker pops and compares them on the falling edge.
// Register readback is table driven; frame, double-buffer, PWM, enable and
// reset corner cases are hand-written sequences with constant expectations.
module tb_seg7_mux_controller;

    logic       clk;
    logic       rst;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] tb_drive;
    logic       tb_oe;
    wire  [7:0] bus_data;
    logic [7:0] hex_out;
    logic [3:0] seg_select;

    int checks = 0;
    int errors = 0;

    // Released bus reads as all ones
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (bus_data[g]);
    end
    assign bus_data = tb_oe ? tb_drive : 8'hzz;

    seg7_mux_controller #(
        .BASE_ADDR  (8'hD0),
        .NUM_DIGITS (4),
        .DWELL_LOG2 (4)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .BUS_ADDR   (bus_addr),
        .BUS_DATA   (bus_data),
        .BUS_WE     (bus_we),
        .HEX_OUT    (hex_out),
        .SEG_SELECT (seg_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------------------------------------------------------- model
    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    typedef struct packed {
        logic [7:0] hex;
        logic [3:0] sel;
    } exp_t;

    exp_t       sb_q[$];
    logic [15:0] m_stage, m_act;
    logic [3:0]  m_dps, m_dpa, m_bright, m_dwell;
    logic [1:0]  m_idx;
    logic        m_en;

    function automatic exp_t model_out();
        exp_t       e;
        logic [3:0] nib;
        logic       on;
        on  = m_en && (m_dwell <= m_bright);
        nib = m_act[4*m_idx +: 4];
        e.sel = on ? ~(4'b0001 << m_idx) : 4'hF;
        e.hex = on ? {~m_dpa[m_idx], ~seg_ref(nib)} : 8'hFF;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stage  <= '0;
            m_act    <= '0;
            m_dps    <= '0;
            m_dpa    <= '0;
            m_en     <= 1'b0;
            m_bright <= 4'hF;
            m_dwell  <= '0;
            m_idx    <= '0;
            sb_q.delete();
        end else begin
            sb_q.push_back(model_out());
            if (m_dwell == 4'hF && m_idx == 2'd3) begin
                m_act <= m_stage;
                m_dpa <= m_dps;
            end
            if (bus_we) begin
                case (bus_addr)
                    8'hD0: m_stage[7:0]  <= bus_data;
                    8'hD1: m_stage[15:8] <= bus_data;
                    8'hD2: m_dps         <= bus_data[3:0];
                    8'hD3: begin
                        m_en     <= bus_data[0];
                        m_bright <= bus_data[7:4];
                    end
                    default: ;
                endcase
            end
            m_dwell <= m_dwell + 4'd1;
            if (m_dwell == 4'hF) m_idx <= m_idx + 2'd1;
        end
    end

    // Scoreboard checker: one expected output pair per clock
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_sel", 32'(seg_select), 32'(e.sel));
            check("sb_hex", 32'(hex_out), 32'(e.hex));
        end
    end

    // ---------------------------------------------------------------- bus tasks
    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        bus_addr = addr;
        tb_drive = data;
        tb_oe    = 1'b1;
        bus_we   = 1'b1;
        @(posedge clk); #2;
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] addr, input logic [7:0] exp, input string name);
        bus_addr = addr;
        bus_we   = 1'b0;
        @(posedge clk); #2;
        check(name, 32'(bus_data), 32'(exp));
        bus_addr = 8'h00;
        @(posedge clk); #2;
    endtask

    task automatic wait_sel(input logic [3:0] val, input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (seg_select == val) return;
        end
        timeout_fail(name);
    endtask

    // Lit run length of digit 0 and dark gap before digit 1
    task automatic measure_pwm(input int exp_lit, input int exp_dark, input string name);
        int n_lit;
        int n_dark;
        wait_sel(4'hF, {name, "_dark"});
        wait_sel(4'hE, {name, "_lit"});
        n_lit  = 1;
        n_dark = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (seg_select != 4'hE) break;
            n_lit++;
        end
        for (int i = 0; i < 20; i++) begin
            if (seg_select != 4'hF) break;
            n_dark++;
            @(negedge clk);
        end
        check({name, "_lit_cycles"}, 32'(n_lit), 32'(exp_lit));
        check({name, "_dark_cycles"}, 32'(n_dark), 32'(exp_dark));
        check({name, "_next_digit"}, 32'(seg_select), 32'h0000000D);
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic       do_wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd_exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] snap;
        logic [7:0] frame_hex [4];

        vecs[0] = '{1'b1, 8'hD2, 8'h05, 8'h05};  // DPMASK readback
        vecs[1] = '{1'b1, 8'hD3, 8'hFF, 8'hF1};  // CTRL reserved bits read 0
        vecs[2] = '{1'b0, 8'hD4, 8'h00, 8'hFF};  // past window: bus released
        vecs[3] = '{1'b1, 8'hD2, 8'hFF, 8'h0F};  // DP bits above digit count dropped
        vecs[4] = '{1'b1, 8'hD0, 8'h34, 8'h34};
        vecs[5] = '{1'b1, 8'hD1, 8'h12, 8'h12};
        vecs[6] = '{1'b0, 8'hCF, 8'h00, 8'hFF};  // below window: bus released
        vecs[7] = '{1'b1, 8'hD2, 8'h00, 8'h00};
        vecs[8] = '{1'b0, 8'hD3, 8'h00, 8'hF1};
        vecs[9] = '{1'b0, 8'hD0, 8'h00, 8'h34};

        frame_hex[0] = 8'h99;  // '4'
        frame_hex[1] = 8'hB0;  // '3'
        frame_hex[2] = 8'hA4;  // '2'
        frame_hex[3] = 8'hF9;  // '1'

        rst      = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 8'h00;
        tb_drive = 8'h00;
        tb_oe    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_hex", 32'(hex_out), 32'h000000FF);
        check("rst_sel", 32'(seg_select), 32'h0000000F);
        check("rst_bus", 32'(bus_data), 32'h000000FF);
        rst = 1'b0;
        @(posedge clk); #2;

        // Register write/readback table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, vecs[i].rd_exp, $sformatf("reg_rd_%0d", i));
        end

        // Full frame after commit: digits 3..0 show 1,2,3,4, 16 cycles each
        wait_sel(4'h7, "frame_sync3");
        wait_sel(4'hE, "frame_sync0");
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            check("frame_sel", 32'(seg_select), 32'(~(4'b0001 << (i / 16)) & 4'hF));
            check("frame_hex", 32'(hex_out), 32'(frame_hex[i / 16]));
        end

        // Mid-frame write stays hidden until the next frame
        wait_sel(4'hE, "db_mid0");
        bus_write(8'hD0, 8'hAA);
        wait_sel(4'hD, "db_mid1");
        check("db_mid_old", 32'(hex_out), 32'h000000B0);
        wait_sel(4'hE, "db_mid_next");
        check("db_mid_new", 32'(hex_out), 32'h00000088);

        // Write landing exactly on the commit edge waits one more frame
        for (int i = 0; i < 100; i++) begin
            if (m_dwell == 4'hF && m_idx == 2'd3) break;
            @(posedge clk); #2;
            if (i == 99) timeout_fail("db_commit_find");
        end
        bus_write(8'hD0, 8'h55);
        wait_sel(4'hE, "db_commit_a");
        check("db_commit_old", 32'(hex_out), 32'h00000088);
        wait_sel(4'h7, "db_commit_b");
        wait_sel(4'hE, "db_commit_c");
        check("db_commit_new", 32'(hex_out), 32'h00000092);

        // Brightness PWM
        bus_write(8'hD3, 8'h31);
        measure_pwm(4, 12, "pwm3");
        bus_write(8'hD3, 8'h01);
        measure_pwm(1, 15, "pwm0");

        // Enable toggle while digit 2 is lit
        bus_write(8'hD3, 8'hF1);
        wait_sel(4'hB, "en_digit2");
        bus_write(8'hD3, 8'hF0);
        @(posedge clk); #1;
        check("en_off_sel", 32'(seg_select), 32'h0000000F);
        check("en_off_hex", 32'(hex_out), 32'h000000FF);
        #1;
        repeat (10) begin
            @(posedge clk);
        end
        #2;
        bus_write(8'hD3, 8'hF1);
        snap = m_idx;
        @(posedge clk); #1;
        check("en_resume_sel", 32'(seg_select), 32'(~(4'b0001 << snap) & 4'hF));
        #1;

        // Asynchronous reset in the middle of a readback cycle
        bus_addr = 8'hD3;
        bus_we   = 1'b0;
        @(posedge clk); #2;
        check("pre_rst_bus", 32'(bus_data), 32'h000000F1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_hex", 32'(hex_out), 32'h000000FF);
        check("async_rst_sel", 32'(seg_select), 32'h0000000F);
        check("async_rst_bus", 32'(bus_data), 32'h000000FF);
        bus_addr = 8'h00;
        @(posedge clk); #2;
        rst = 1'b0;
        bus_read(8'hD3, 8'hF0, "post_rst_ctrl");
        bus_read(8'hD0, 8'h00, "post_rst_d0");
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
